// File: rtl/vxe_axi4_mem_slave.sv
// AXI4 slave scratch memory for one VxEngine master port: serves one transaction at a
// time as 64-bit INCR beats, with a fixed read latency and byte-strobed writes.
module vxe_axi4_mem_slave #(
    parameter int unsigned ID_WIDTH = 7,
    parameter int unsigned MEM_AW   = 12,
    parameter int unsigned RD_LAT   = 2
) (
    input  logic                clk,
    input  logic                nrst,
    // write address
    input  logic [ID_WIDTH-1:0] S_AXI4_AWID,
    input  logic [39:0]         S_AXI4_AWADDR,
    input  logic [7:0]          S_AXI4_AWLEN,
    input  logic [2:0]          S_AXI4_AWSIZE,
    input  logic [1:0]          S_AXI4_AWBURST,
    input  logic                S_AXI4_AWVALID,
    output logic                S_AXI4_AWREADY,
    // write data
    input  logic [63:0]         S_AXI4_WDATA,
    input  logic [7:0]          S_AXI4_WSTRB,
    input  logic                S_AXI4_WLAST,
    input  logic                S_AXI4_WVALID,
    output logic                S_AXI4_WREADY,
    // write response
    output logic [ID_WIDTH-1:0] S_AXI4_BID,
    output logic [1:0]          S_AXI4_BRESP,
    output logic                S_AXI4_BVALID,
    input  logic                S_AXI4_BREADY,
    // read address
    input  logic [ID_WIDTH-1:0] S_AXI4_ARID,
    input  logic [39:0]         S_AXI4_ARADDR,
    input  logic [7:0]          S_AXI4_ARLEN,
    input  logic [2:0]          S_AXI4_ARSIZE,
    input  logic [1:0]          S_AXI4_ARBURST,
    input  logic                S_AXI4_ARVALID,
    output logic                S_AXI4_ARREADY,
    // read data
    output logic [ID_WIDTH-1:0] S_AXI4_RID,
    output logic [63:0]         S_AXI4_RDATA,
    output logic [1:0]          S_AXI4_RRESP,
    output logic                S_AXI4_RLAST,
    output logic                S_AXI4_RVALID,
    input  logic                S_AXI4_RREADY
);

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdData,
        StWrData,
        StWrResp
    } state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [2:0] Size64     = 3'd3;

    state_e              state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [MEM_AW-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          beat_q, beat_d;
    logic [15:0]         lat_q, lat_d;
    logic                err_q, err_d;
    logic                last_wr_q, last_wr_d;
    logic [63:0]         rdata_q, rdata_d;

    logic [63:0]         mem [2**MEM_AW];

    logic                grant_rd, grant_wr;
    logic                r_hs, w_hs, last_beat;
    logic                rd_en;
    logic [MEM_AW-1:0]   rd_addr;
    logic [MEM_AW-1:0]   ar_word, aw_word;

    assign ar_word = S_AXI4_ARADDR[MEM_AW+2:3];
    assign aw_word = S_AXI4_AWADDR[MEM_AW+2:3];

    // On a collision the channel not granted last time wins (last_wr_q=0 means READ).
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (state_q == StIdle) begin
            if (S_AXI4_ARVALID && S_AXI4_AWVALID) begin
                grant_rd = last_wr_q;
                grant_wr = !last_wr_q;
            end else begin
                grant_rd = S_AXI4_ARVALID;
                grant_wr = S_AXI4_AWVALID;
            end
        end
    end

    assign S_AXI4_ARREADY = grant_rd;
    assign S_AXI4_AWREADY = grant_wr;

    assign last_beat     = (beat_q == len_q);
    assign S_AXI4_RVALID = (state_q == StRdData);
    assign S_AXI4_RLAST  = S_AXI4_RVALID && last_beat;
    assign S_AXI4_RRESP  = (S_AXI4_RVALID && err_q) ? RespSlvErr : RespOkay;
    assign S_AXI4_RDATA  = rdata_q;
    assign S_AXI4_RID    = id_q;
    assign S_AXI4_WREADY = (state_q == StWrData);
    assign S_AXI4_BVALID = (state_q == StWrResp);
    assign S_AXI4_BRESP  = (S_AXI4_BVALID && err_q) ? RespSlvErr : RespOkay;
    assign S_AXI4_BID    = id_q;

    assign r_hs = S_AXI4_RVALID && S_AXI4_RREADY;
    assign w_hs = S_AXI4_WREADY && S_AXI4_WVALID;

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        beat_d    = beat_q;
        lat_d     = lat_q;
        err_d     = err_q;
        last_wr_d = last_wr_q;
        unique case (state_q)
            StIdle: begin
                if (grant_rd) begin
                    id_d      = S_AXI4_ARID;
                    addr_d    = ar_word;
                    len_d     = S_AXI4_ARLEN;
                    beat_d    = 8'd0;
                    lat_d     = 16'd0;
                    err_d     = (S_AXI4_ARSIZE != Size64) || (S_AXI4_ARBURST != BurstIncr);
                    last_wr_d = 1'b0;
                    state_d   = (RD_LAT == 0) ? StRdData : StRdWait;
                end else if (grant_wr) begin
                    id_d      = S_AXI4_AWID;
                    addr_d    = aw_word;
                    len_d     = S_AXI4_AWLEN;
                    beat_d    = 8'd0;
                    lat_d     = 16'd0;
                    err_d     = (S_AXI4_AWSIZE != Size64) || (S_AXI4_AWBURST != BurstIncr);
                    last_wr_d = 1'b1;
                    state_d   = StWrData;
                end
            end
            StRdWait: begin
                if (lat_q == 16'(RD_LAT - 1)) begin
                    state_d = StRdData;
                end else begin
                    lat_d = lat_q + 16'd1;
                end
            end
            StRdData: begin
                if (r_hs) begin
                    addr_d = addr_q + MEM_AW'(1);
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = StIdle;
                    end
                end
            end
            StWrData: begin
                if (w_hs) begin
                    addr_d = addr_q + MEM_AW'(1);
                    beat_d = beat_q + 8'd1;
                    if (S_AXI4_WLAST != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d = StWrResp;
                    end
                end
            end
            StWrResp: begin
                if (S_AXI4_BREADY) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Read data is fetched one cycle ahead so RDATA is already valid when RVALID rises,
    // and is held untouched while the master stalls.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = addr_q;
        if (grant_rd) begin
            rd_en   = 1'b1;
            rd_addr = ar_word;
        end else if (state_q == StRdWait) begin
            rd_en = 1'b1;
        end else if (r_hs) begin
            rd_en   = 1'b1;
            rd_addr = addr_q + MEM_AW'(1);
        end
    end

    assign rdata_d = rd_en ? mem[rd_addr] : rdata_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= StIdle;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            lat_q     <= 16'd0;
            err_q     <= 1'b0;
            last_wr_q <= 1'b0;
            rdata_q   <= 64'd0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            err_q     <= err_d;
            last_wr_q <= last_wr_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int b = 0; b < 8; b++) begin
                if (S_AXI4_WSTRB[b]) begin
                    mem[addr_q][8*b +: 8] <= S_AXI4_WDATA[8*b +: 8];
                end
            end
        end
    end

    // Byte-offset and upper address bits alias onto the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{S_AXI4_AWADDR[39:MEM_AW+3], S_AXI4_AWADDR[2:0],
                                S_AXI4_ARADDR[39:MEM_AW+3], S_AXI4_ARADDR[2:0]};

endmodule

// File: doc/vxe_axi4_mem_slave.md
Name: vxe_axi4_mem_slave

Overview:
- Synthesizable AXI4 slave memory model that consumes the traffic from one VxEngine master port (M0 or M1) of vxe_top.
- Used in top-level benches, and as FPGA on-chip scratch memory, in place of external DRAM.
- Services one transaction at a time: INCR bursts of 64-bit beats, a configurable read latency, and byte-strobed writes into an internal RAM.

Parameters:
ID_WIDTH, 7, width of the AWID/BID/ARID/RID fields
MEM_AW, 12, log2 of RAM depth in 64-bit words (default 4096 words = 32 KiB)
RD_LAT, 2, idle cycles between AR acceptance and the first R beat (0 allowed)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
S_AXI4_AWID  in  ID_WIDTH  write ID
S_AXI4_AWADDR  in  40  write byte address
S_AXI4_AWLEN  in  8  beats-1
S_AXI4_AWSIZE  in  3  beat size
S_AXI4_AWBURST  in  2  burst type
S_AXI4_AWVALID/AWREADY  in/out  1  AW handshake
S_AXI4_WDATA  in  64  write data
S_AXI4_WSTRB  in  8  byte enables
S_AXI4_WLAST  in  1  last beat
S_AXI4_WVALID/WREADY  in/out  1  W handshake
S_AXI4_BID  out  ID_WIDTH  response ID
S_AXI4_BRESP  out  2  write response
S_AXI4_BVALID/BREADY  out/in  1  B handshake
S_AXI4_ARID, ARADDR, ARLEN, ARSIZE, ARBURST  in  ID_WIDTH/40/8/3/2  read address channel
S_AXI4_ARVALID/ARREADY  in/out  1  AR handshake
S_AXI4_RID  out  ID_WIDTH  read ID
S_AXI4_RDATA  out  64  read data
S_AXI4_RRESP  out  2  read response
S_AXI4_RLAST  out  1  last beat
S_AXI4_RVALID/RREADY  out/in  1  R handshake
(AxLOCK/AxCACHE/AxPROT are not ported; the instantiating level leaves them unconnected.)

Behaviour:
- Clock and reset: single clock clk; nrst is asynchronous, active-low.
- Reset state: FSM=IDLE, beat counter=0, latency counter=0, arbitration pointer=READ.
- Reset values of outputs: every valid/ready, BRESP, RRESP, RLAST, RDATA, BID and RID are 0.
- RAM contents are not reset.
- A reset asserted mid-burst aborts the burst immediately; no B or R response is ever issued for it.
- FSM states: IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP.
- IDLE, ready generation:
  - ARREADY = ARVALID & read granted.
  - AWREADY = AWVALID & write granted.
  - Both are 0 in every state other than IDLE.
- IDLE, arbitration:
  - If only one of ARVALID/AWVALID is high, that channel is granted.
  - If both are high, the channel opposite the pointer's last grant wins; the pointer flips on every grant.
  - Exactly one address handshake completes per cycle.
- AR accept: latch ID, word address (ADDR[MEM_AW+2:3]), LEN and an error flag.
  - Error flag = (ARSIZE != 3) | (ARBURST != INCR).
  - Next state is RD_WAIT if RD_LAT > 0, otherwise RD_DATA.
- RD_WAIT: count RD_LAT cycles, then go to RD_DATA.
- RD_DATA:
  - RVALID=1; RDATA=mem[addr], registered, loaded one cycle ahead so it is valid when RVALID rises.
  - RRESP = error ? SLVERR(2'b10) : OKAY; RLAST=1 when beat == LEN.
  - Outputs stay stable while RREADY=0.
  - On RVALID&RREADY: addr+1, beat+1; on the last beat return to IDLE with RVALID=0 the next cycle.
- Address handling: word address wraps modulo 2^MEM_AW; upper address bits are ignored (aliasing). Beats use 64-bit INCR regardless of AxSIZE/AxBURST; only the response carries the error.
- AW accept: latch the same fields as AR; go to WR_DATA.
- WR_DATA:
  - WREADY=1. Each W handshake writes the bytes whose WSTRB bit is set, then addr+1.
  - On the beat where beat == LEN: go to WR_RESP.
  - Any beat with WLAST != (beat == LEN) sets a sticky error flag.
- WR_RESP:
  - BVALID=1, BID=latched ID, BRESP = error ? SLVERR : OKAY.
  - Hold until BREADY, then return to IDLE.
- No W data is accepted before its AW; W data arriving early waits (WREADY=0).
- Throughput: one beat per cycle when RREADY/WVALID are held high. Minimum gap between transactions is one IDLE cycle.

Test Plan:
- Single write then read: AW addr 0x100, LEN=0, WDATA 0x1122334455667788, WSTRB 0xFF -> BRESP=OKAY, BID matches AWID. AR addr 0x100 -> first RVALID exactly RD_LAT+1 cycles after the AR handshake, RDATA=0x1122334455667788, RLAST=1.
- Burst with backpressure: write 8 beats (LEN=7) from 0x0 with data i*0x0101010101010101 -> all 8 words stored. Read back with RREADY toggling every cycle -> 8 beats in order, RLAST only on beat 7, data stable while stalled.
- Partial strobes: write 0xFFFFFFFFFFFFFFFF, then write 0 with WSTRB 0x0F -> readback 0xFFFFFFFF00000000.
- Errors and wrap:
  - ARSIZE=2 -> data is returned with RRESP=SLVERR on every beat.
  - WLAST early on beat 1 of LEN=3 -> 4 beats accepted, BRESP=SLVERR.
  - Burst starting at word 2^MEM_AW-1 -> second beat lands at word 0.
- Simultaneous AR and AW in IDLE after reset -> write granted first (pointer=READ), read served next. Repeated collisions alternate grants.
- Reset mid-read (nrst low during beat 3 of LEN=7) -> all outputs 0 asynchronously, FSM returns to IDLE, no further R beats. RAM data written earlier is intact on a subsequent read.
